// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the NOP substituted on a misaligned fetch, and register reset values.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam fetch_state_t RST_STATE    = REQ;
    localparam logic [31:0]  RST_INST     = 32'h0000_0000;
    localparam logic [31:0]  RST_INST_PC  = 32'h0000_0000;
    localparam logic         RST_FAULT    = 1'b0;
    localparam logic [31:0]  RST_FETCH_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues one memory request per PC, holds the
// returned word for decode, and stalls the PC register until decode takes
// it. A redirect flushes whatever fetch is in flight; a response that was
// already requested is drained in DROP so it cannot be mistaken for the
// response to the next request.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(fetch_pkg::NOP_INST)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] PC,
    input  logic            Redirect,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            inst_ready,
    output logic            PCStall
);
    import fetch_pkg::*;

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] inst_reg;
    logic [XLEN-1:0] inst_pc_reg;
    logic            inst_fault_reg;

    logic            misaligned;
    logic            latch_pc;
    logic            load_rsp;
    logic            load_nop;

    assign misaligned    = |PC[1:0];
    assign imem_req_addr = PC;
    assign inst          = inst_reg;
    assign inst_pc       = inst_pc_reg;
    assign inst_fault    = inst_fault_reg;

    // Next-state, handshake outputs and register load strobes.
    always_comb begin
        state_next     = state_reg;
        latch_pc       = 1'b0;
        load_rsp       = 1'b0;
        load_nop       = 1'b0;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        PCStall        = 1'b1;

        case (state_reg)
            REQ: begin
                if (Redirect) begin
                    // PC is about to change; do not request the stale address.
                    state_next = REQ;
                end else if (misaligned) begin
                    load_nop   = 1'b1;
                    state_next = HOLD;
                end else begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        latch_pc   = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (Redirect) begin
                        state_next = REQ;
                    end else begin
                        load_rsp   = 1'b1;
                        state_next = HOLD;
                    end
                end else if (Redirect) begin
                    state_next = DROP;
                end
            end
            HOLD: begin
                if (Redirect) begin
                    state_next = REQ;
                end else begin
                    inst_valid = 1'b1;
                    if (inst_ready) begin
                        PCStall    = 1'b0;
                        state_next = REQ;
                    end
                end
            end
            DROP: begin
                // Orphaned response is swallowed; a redirect here changes nothing.
                if (imem_rsp_valid) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = REQ;
            end
        endcase

        if (Redirect) begin
            PCStall = 1'b0;
        end

        // Reset dominates every output regardless of the current state.
        if (RST) begin
            imem_req_valid = 1'b0;
            inst_valid     = 1'b0;
            PCStall        = 1'b1;
        end
    end

    // State, captured request PC and the instruction output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= RST_STATE;
            fetch_pc_reg   <= XLEN'(RST_FETCH_PC);
            inst_reg       <= XLEN'(RST_INST);
            inst_pc_reg    <= XLEN'(RST_INST_PC);
            inst_fault_reg <= RST_FAULT;
        end else begin
            state_reg <= state_next;
            if (latch_pc) begin
                fetch_pc_reg <= PC;
            end
            if (load_nop) begin
                inst_reg       <= NOP_INST;
                inst_pc_reg    <= PC;
                inst_fault_reg <= 1'b1;
            end else if (load_rsp) begin
                inst_reg       <= imem_rsp_data;
                inst_pc_reg    <= fetch_pc_reg;
                inst_fault_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scripted bench for fetch_unit. Expected decode transfers are queued when
// the stimulus that causes them is driven and popped when decode accepts.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        redirect;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_ready;
    logic        pc_stall;

    exp_t        sb[$];
    logic [31:0] redirect_target;
    int          tests_run;
    int          tests_failed;
    int          stall_low_cnt;
    int          cycle_cnt;

    fetch_unit dut (
        .CLK            (clk),
        .RST            (rst),
        .PC             (pc),
        .Redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .inst_ready     (inst_ready),
        .PCStall        (pc_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: score any decode transfer, then advance the PC register model.
    task automatic tick();
        exp_t        e;
        logic        stall_now;
        logic [31:0] pc_next;
        #1;
        if (inst_valid && inst_ready) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_inst: got inst=%h pc=%h fault=%b, no transfer expected",
                         inst, inst_pc, inst_fault);
            end else begin
                e = sb.pop_front();
                if ({inst, inst_pc, inst_fault} !== {e.inst, e.pc, e.fault}) begin
                    tests_failed++;
                    $display("FAIL inst_xfer: got inst=%h pc=%h fault=%b, want inst=%h pc=%h fault=%b",
                             inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
                end else begin
                    $display("[TB] xfer inst=%h pc=%h fault=%b", inst, inst_pc, inst_fault);
                end
            end
        end
        if (!pc_stall) stall_low_cnt++;
        stall_now = pc_stall;
        pc_next   = redirect ? redirect_target : pc + 32'd4;
        cycle_cnt++;
        @(posedge clk);
        @(negedge clk);
        if (!stall_now) pc = pc_next;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: got req_valid=%b stall=%b inst_valid=%b, want 0 1 0",
                     imem_req_valid, pc_stall, inst_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || pc_stall !== 1'b1 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got req_valid=%b addr=%h stall=%b inst_valid=%b, want 1 0 1 0",
                     imem_req_valid, imem_req_addr, pc_stall, inst_valid);
        end
        tests_run++;
        if ({inst, inst_pc, inst_fault} !== 65'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: got inst=%h pc=%h fault=%b, want 0 0 0", inst, inst_pc, inst_fault);
        end
    endtask

    task automatic test_basic();
        stall_low_cnt  = 0;
        imem_req_ready = 1'b1;
        sb.push_back('{32'h0050_0093, 32'h0, 1'b0});
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        tick();
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b1;
        #1;
        tests_run++;
        if (inst_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_latency: got inst_valid=%b, want 1", inst_valid);
        end
        tick();
        inst_ready = 1'b0;
        #1;
        tests_run++;
        if (stall_low_cnt != 1) begin
            tests_failed++;
            $display("FAIL basic_stall_pulse: got %0d PCStall-low cycles, want 1", stall_low_cnt);
        end
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
            tests_failed++;
            $display("FAIL basic_next_req: got req_valid=%b addr=%h, want 1 00000004", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_req_stall();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4 || pc_stall !== 1'b1) begin
                tests_failed++;
                $display("FAIL req_stall[%0d]: got req_valid=%b addr=%h stall=%b, want 1 00000004 1",
                         i, imem_req_valid, imem_req_addr, pc_stall);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        sb.push_back('{32'h00A0_0113, 32'h4, 1'b0});
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0113;
        tick();
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b1;
        tick();
    endtask

    task automatic test_redirect_wait();
        // inst_ready stays high: any leaked instruction shows up as unexpected.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'h100;
        #1;
        tests_run++;
        if (pc_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_wait_stall: got PCStall=%b, want 0", pc_stall);
        end
        tick();
        redirect = 1'b0;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL redir_drop: got req_valid=%b stall=%b, want 0 1", imem_req_valid, pc_stall);
        end
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_new_req: got req_valid=%b addr=%h inst_valid=%b, want 1 00000100 0",
                     imem_req_valid, imem_req_addr, inst_valid);
        end
        imem_req_ready = 1'b1;
        sb.push_back('{32'h0011_0113, 32'h100, 1'b0});
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0011_0113;
        tick();
        imem_rsp_valid = 1'b0;
        tick();
    endtask

    task automatic test_redirect_hold();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0220_0193;
        tick();
        imem_rsp_valid  = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'h200;
        #1;
        tests_run++;
        if (inst_valid !== 1'b0 || pc_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_hold: got inst_valid=%b stall=%b, want 0 0", inst_valid, pc_stall);
        end
        tick();
        redirect = 1'b0;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_hold_req: got req_valid=%b addr=%h inst_valid=%b, want 1 00000200 0",
                     imem_req_valid, imem_req_addr, inst_valid);
        end
    endtask

    task automatic test_misaligned();
        inst_ready      = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'h6;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b0 || pc_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_req: got req_valid=%b stall=%b, want 0 0", imem_req_valid, pc_stall);
        end
        tick();
        redirect = 1'b0;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL misaligned_req: got req_valid=%b, want 0", imem_req_valid);
        end
        sb.push_back('{32'h0000_0013, 32'h6, 1'b1});
        tick();
        inst_ready = 1'b1;
        #1;
        tests_run++;
        if (inst_valid !== 1'b1 || inst_fault !== 1'b1) begin
            tests_failed++;
            $display("FAIL misaligned_hold: got inst_valid=%b fault=%b, want 1 1", inst_valid, inst_fault);
        end
        tick();
        // PC is now 0xA, also misaligned: steer away before it is fetched.
        inst_ready      = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'h300;
        tick();
        redirect = 1'b0;
    endtask

    task automatic test_reset_midflight();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst            = 1'b1;
        pc             = 32'h0;
        #1;
        tests_run++;
        if (imem_req_valid !== 1'b0 || pc_stall !== 1'b1 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid: got req_valid=%b stall=%b inst_valid=%b, want 0 1 0",
                     imem_req_valid, pc_stall, inst_valid);
        end
        tick();
        rst = 1'b0;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        inst_ready     = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        tests_run++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_stale_rsp: got inst_valid=%b req_valid=%b addr=%h, want 0 1 00000000",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        sb.push_back('{32'h0030_0213, 32'h0, 1'b0});
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0030_0213;
        tick();
        imem_rsp_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int start_cycle;
        start_cycle   = cycle_cnt;
        stall_low_cnt = 0;
        inst_ready    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_req_ready = 1'b1;
            sb.push_back('{32'h1000_0000 + 32'(i), 32'h4 + 32'(4 * i), 1'b0});
            tick();
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'h1000_0000 + 32'(i);
            tick();
            imem_rsp_valid = 1'b0;
            tick();
        end
        tests_run++;
        if (cycle_cnt - start_cycle != 9 || stall_low_cnt != 3) begin
            tests_failed++;
            $display("FAIL back_to_back: got %0d cycles %0d advances, want 9 cycles 3 advances",
                     cycle_cnt - start_cycle, stall_low_cnt);
        end
        tests_run++;
        if (pc !== 32'h10) begin
            tests_failed++;
            $display("FAIL b2b_pc: got pc=%h, want 00000010", pc);
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        stall_low_cnt   = 0;
        cycle_cnt       = 0;
        rst             = 1'b1;
        pc              = 32'h0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        inst_ready      = 1'b0;
        @(negedge clk);

        test_reset();
        test_basic();
        test_req_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_misaligned();
        test_reset_midflight();
        test_back_to_back();

        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly downstream of the program counter register. Takes the current `PC` and issues a valid/ready request to instruction memory. Captures the response and presents the instruction with its PC to decode through a valid/ready handshake. Drives `PCStall` back to the PC register, which loads `PCNext` only when `PCStall`=0. Also handles control-flow redirects by flushing any in-flight fetch.

## Interface
Parameters:
- `XLEN`, 32, address/data width.
- `NOP_INST`, 32'h00000013, instruction word emitted on a misaligned fetch.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `PC` in XLEN: current PC from the PC register; stable whenever `PCStall`=1.
- `Redirect` in 1: branch/jump taken this cycle; flushes the fetch.
- `imem_req_valid` out 1: memory request valid.
- `imem_req_addr` out XLEN: request address.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_rsp_valid` in 1: response data valid; at most one response per accepted request, in order.
- `imem_rsp_data` in XLEN: instruction word.
- `inst_valid` out 1: instruction available to decode.
- `inst` out XLEN: instruction word.
- `inst_pc` out XLEN: PC of `inst`.
- `inst_fault` out 1: `inst` is a substituted NOP for a misaligned PC.
- `inst_ready` in 1: decode accepts the instruction.
- `PCStall` out 1: hold the PC register.

## Operation
- FSM states: REQ, WAIT, HOLD, DROP. Reset state is REQ.
- REQ:
  - `imem_req_valid`=1 and `imem_req_addr`=`PC`.
  - On `imem_req_ready`: latch `PC` into `fetch_pc`, go to WAIT.
  - If `PC[1:0]`≠0: no request is issued. Load `inst`=NOP_INST, `inst_pc`=`PC`, `inst_fault`=1, and go to HOLD.
- WAIT: on `imem_rsp_valid`, load `inst`=`imem_rsp_data`, `inst_pc`=`fetch_pc`, `inst_fault`=0, and go to HOLD.
- HOLD:
  - `inst_valid`=1.
  - On `inst_ready`: `PCStall`=0 for that cycle (PC advances to `PCNext`), then go to REQ.
- DROP: wait for the orphaned response. On `imem_rsp_valid`, discard it and go to REQ.
- `PCStall`=1 in every state, except HOLD with `inst_ready`=1, and any cycle with `Redirect`=1.
- Redirect handling:
  - REQ: `imem_req_valid` is forced to 0 that cycle; `PCStall`=0 so the PC loads the target; stay in REQ.
  - WAIT without `imem_rsp_valid`: go to DROP.
  - WAIT with `imem_rsp_valid`: discard the response, go to REQ.
  - HOLD: `inst_valid` is forced to 0 that cycle, so no transfer occurs even if `inst_ready`=1. The held instruction is discarded; go to REQ.
  - DROP: stay in DROP.
- Output registers are held while in HOLD. `inst` and `inst_pc` are don't-care when `inst_valid`=0, but they are not changed outside the load events above.

## Timing
- Reset values: state=REQ; `inst`=0, `inst_pc`=0, `inst_fault`=0, `fetch_pc`=0. Output effects of reset:
  - `inst_valid`=0.
  - `imem_req_valid`=1 the cycle after reset deasserts. It is 0 while `RST`=1.
  - `PCStall`=1 while `RST`=1.
- `RST` mid-operation overrides everything, including a pending response. A response arriving after reset is ignored, because the state is REQ, not WAIT.
- Latency: response cycle N → `inst_valid`=1 at cycle N+1. With a zero-wait memory (ready and rsp each one cycle after request), throughput is one instruction per 3 cycles.
- `imem_req_valid`, once asserted without redirect, stays high with a stable address until `imem_req_ready`.
- Misaligned PC: `inst_valid` rises the cycle after REQ; no memory traffic.

## Structure
- Shared package `fetch_pkg`:
  - state enum (REQ, WAIT, HOLD, DROP);
  - `NOP_INST` constant;
  - reset values.
- Single module; no sub-module. FSM, output registers and `fetch_pc` live in one always block plus a combinational output/next-state block.

## Test plan
- Reset then memory with ready=1 and 1-cycle response for PC=0x0 returning 0x00500093 → `inst_valid`=1, `inst`=0x00500093, `inst_pc`=0x0, exactly one `PCStall`=0 cycle on accept.
- `imem_req_ready` held low 3 cycles at PC=0x4 → `imem_req_valid` and `imem_req_addr`=0x4 stable throughout, `PCStall`=1.
- `Redirect` in WAIT, then response 0xDEADBEEF arrives 2 cycles later → response discarded (no `inst_valid`), next request issued at the redirected PC.
- `Redirect` together with `inst_ready` in HOLD → `inst_valid`=0 that cycle, no transfer, new request the next cycle.
- PC=0x6 → no memory request; `inst`=0x00000013, `inst_fault`=1, `inst_pc`=0x6.
- `RST` asserted while in WAIT, stale response arrives 1 cycle after reset release → ignored; fresh request issued at PC=0.
